// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle for fifo_sync_param.
// master drives requests and data; slave is the FIFO itself.
interface fifo_sync_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  cs;
    logic                  wr_en;
    logic                  rd_en;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output cs, wr_en, rd_en, err_clr, data_in,
        input  data_out, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  cs, wr_en, rd_en, err_clr, data_in,
        output data_out, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Synchronous parameterised FIFO with registered or first-word-fall-through read.
// Define FIFO_SYNC_PARAM_ERR_EN to enable the sticky overflow/underflow flags.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_sync_param_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;

    assign full   = (cnt == CW'(FIFO_DEPTH));
    assign empty  = (cnt == '0);
    assign wr_acc = bus.cs && bus.wr_en && !full;
    assign rd_acc = bus.cs && bus.rd_en && !empty;

    assign bus.count        = cnt;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (cnt >= CW'(AF_THRESH));
    assign bus.almost_empty = (cnt <= CW'(AE_THRESH));

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out = empty ? '0 : mem[rd_ptr];
            assign bus.rd_valid = 1'b0;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) dout_q <= mem[rd_ptr];
                end
            end

            assign bus.data_out = dout_q;
            assign bus.rd_valid = valid_q;
        end
    endgenerate

`ifdef FIFO_SYNC_PARAM_ERR_EN
    logic ovf_q;
    logic unf_q;

    // Clear wins over set; everything is frozen while cs is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (bus.cs) begin
            if (bus.err_clr) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                if (bus.wr_en && full)  ovf_q <= 1'b1;
                if (bus.rd_en && empty) unf_q <= 1'b1;
            end
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: a standard-read instance and an FWFT instance.
module tb_fifo_sync_param;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
`ifdef FIFO_SYNC_PARAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_sync_param_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus_a ();
    fifo_sync_param_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus_b ();

    fifo_sync_param #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
    );

    fifo_sync_param #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
    );

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] sb_q[$];     // expected rd_valid words of dut_a, in order
    logic [DW-1:0] model_q[$];  // contents of dut_a
    logic [DW-1:0] exp_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Every rd_valid pulse must match the next expected word.
    always @(negedge clk) begin
        if (rst_n && bus_a.rd_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL rd_valid_unexpected actual=0x%0h required=no_pulse", bus_a.data_out);
            end else begin
                exp_word = sb_q.pop_front();
                if (bus_a.data_out !== exp_word) begin
                    failures++;
                    $display("FAIL rd_data actual=0x%0h required=0x%0h", bus_a.data_out, exp_word);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op_a(input logic w, input logic r, input logic [DW-1:0] d);
        bit wa;
        bit ra;
        wa = bus_a.cs && w && (model_q.size() < DEPTH);
        ra = bus_a.cs && r && (model_q.size() > 0);
        if (ra) sb_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(d);
        bus_a.wr_en   = w;
        bus_a.rd_en   = r;
        bus_a.data_in = d;
        step();
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b0;
    endtask

    task automatic err_clear_a();
        bus_a.err_clr = 1'b1;
        step();
        bus_a.err_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus_a.cs = 0; bus_a.wr_en = 0; bus_a.rd_en = 0; bus_a.err_clr = 0; bus_a.data_in = '0;
        bus_b.cs = 0; bus_b.wr_en = 0; bus_b.rd_en = 0; bus_b.err_clr = 0; bus_b.data_in = '0;

        #12;
        check("rst_count", bus_a.count, 0);
        check("rst_empty", bus_a.empty, 1);
        check("rst_almost_empty", bus_a.almost_empty, 1);
        check("rst_full", bus_a.full, 0);
        check("rst_almost_full", bus_a.almost_full, 0);
        check("rst_rd_valid", bus_a.rd_valid, 0);
        check("rst_data_out", bus_a.data_out, 0);
        check("rst_overflow", bus_a.overflow, 0);
        check("rst_underflow", bus_a.underflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.cs = 1'b1;
        step();

        // Fill with 0x11..0x88.
        for (int i = 0; i < 8; i++) begin
            op_a(1'b1, 1'b0, DW'((i + 1) * 32'h11));
            check("fill_count", bus_a.count, i + 1);
            check("fill_almost_full", bus_a.almost_full, (i + 1) >= 6);
            check("fill_full", bus_a.full, i == 7);
        end

        op_a(1'b1, 1'b0, 32'hDEAD);
        check("ovf_count", bus_a.count, 8);
        check("ovf_full", bus_a.full, 1);
        check("ovf_flag", bus_a.overflow, ERR_EN);
        step();
        check("ovf_sticky", bus_a.overflow, ERR_EN);
        err_clear_a();
        check("ovf_cleared", bus_a.overflow, 0);

        // Drain, expecting 0x11..0x88 in order.
        for (int i = 0; i < 8; i++) begin
            op_a(1'b0, 1'b1, '0);
            check("drain_count", bus_a.count, 7 - i);
            check("drain_almost_empty", bus_a.almost_empty, (7 - i) <= 2);
            check("drain_empty", bus_a.empty, i == 7);
        end
        step();
        check("idle_rd_valid", bus_a.rd_valid, 0);
        check("idle_data_hold", bus_a.data_out, 32'h88);

        // Read and write together on empty: only the write lands.
        op_a(1'b1, 1'b1, 32'h77);
        check("rw_empty_count", bus_a.count, 1);
        check("rw_empty_underflow", bus_a.underflow, ERR_EN);
        step();
        check("rw_empty_no_valid", bus_a.rd_valid, 0);
        err_clear_a();
        check("unf_cleared", bus_a.underflow, 0);

        op_a(1'b1, 1'b0, 32'h01);
        op_a(1'b1, 1'b0, 32'h02);
        op_a(1'b1, 1'b0, 32'h03);
        check("prefill_count", bus_a.count, 4);

        bus_a.cs = 1'b0;
        op_a(1'b1, 1'b1, 32'hBAD);
        check("cs_low_count", bus_a.count, 4);
        bus_a.cs = 1'b1;
        step();
        check("cs_low_no_valid", bus_a.rd_valid, 0);

        // 20 simultaneous read/write cycles wrap both pointers.
        for (int k = 0; k < 20; k++) begin
            op_a(1'b1, 1'b1, DW'(32'h100 + k));
            check("rw_count", bus_a.count, 4);
        end
        for (int k = 0; k < 4; k++) op_a(1'b0, 1'b1, '0);
        check("rw_drain_empty", bus_a.empty, 1);
        step();

        // Asynchronous reset in mid-cycle with five entries stored.
        for (int i = 0; i < 5; i++) op_a(1'b1, 1'b0, DW'(32'hA0 + i));
        check("pre_rst_count", bus_a.count, 5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", bus_a.count, 0);
        check("async_rst_empty", bus_a.empty, 1);
        check("async_rst_almost_full", bus_a.almost_full, 0);
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        op_a(1'b1, 1'b0, 32'h55);
        op_a(1'b0, 1'b1, '0);
        check("post_rst_empty", bus_a.empty, 1);
        step();

        // First-word-fall-through instance.
        bus_b.cs      = 1'b1;
        bus_b.wr_en   = 1'b1;
        bus_b.data_in = 32'hCAFE;
        check("fwft_pre_empty", bus_b.empty, 1);
        step();
        bus_b.wr_en = 1'b0;
        check("fwft_empty", bus_b.empty, 0);
        check("fwft_data", bus_b.data_out, 32'hCAFE);
        check("fwft_rd_valid", bus_b.rd_valid, 0);
        bus_b.wr_en   = 1'b1;
        bus_b.data_in = 32'hBEEF;
        step();
        bus_b.wr_en = 1'b0;
        check("fwft_head_hold", bus_b.data_out, 32'hCAFE);
        check("fwft_count2", bus_b.count, 2);
        bus_b.rd_en = 1'b1;
        step();
        check("fwft_next_head", bus_b.data_out, 32'hBEEF);
        check("fwft_count1", bus_b.count, 1);
        step();
        bus_b.rd_en = 1'b0;
        check("fwft_drained", bus_b.empty, 1);
        check("fwft_rd_valid_end", bus_b.rd_valid, 0);

        step();
        step();
        check("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
